// File: rtl/ws2812_pkg.sv
// ws2812_pkg
// Shared definitions for the WS2812 transmitter and receiver: the receiver
// state enumeration, the word width and the default timing constants.
// CLK_FRE is the clock frequency in Hz and is kept for documentation; the
// cycle counts below assume 27 MHz.
package ws2812_pkg;

  localparam int CLK_FRE       = 27000000;
  localparam int WS2812_WIDTH  = 24;
  localparam int BIT_THRESHOLD = 17;
  localparam int RESET_CYCLES  = 1350;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } rx_state_t;

endpackage

// File: rtl/ws2812_sync.sv
// ws2812_sync
// Two-flop synchronizer for the asynchronous WS2812 line, plus a third flop
// holding the previous synchronized level for edge detection.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset
//   din   - asynchronous line input
//   din_s - synchronized line level
//   rise  - high for one cycle when din_s goes 0 -> 1
//   fall  - high for one cycle when din_s goes 1 -> 0
module ws2812_sync
  import ws2812_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Metastability stage, synchronized stage and the one-cycle-old copy
  // that the edge detectors compare against.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign din_s = r_sync;
  assign rise  = r_sync & ~r_prev;
  assign fall  = ~r_sync & r_prev;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx
// WS2812 NRZ pulse-width receiver. Decodes the single-wire stream into
// colour words (bit 0 arrives first), strobes each completed word, and
// detects frame boundaries from the long low reset gap.
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   din        - asynchronous WS2812 line
//   data_out   - last completed word
//   data_valid - one-cycle strobe, data_out valid in that cycle
//   frame_end  - one-cycle strobe when the reset gap is seen
//   bit_err    - one-cycle strobe on glitch, timeout or partial word
//   word_count - words completed in the current frame, saturating at 511
//   dout       - forwarded line (only with WS2812_RX_FORWARD_EN)
// Build option: define WS2812_RX_FORWARD_EN to add the dout forwarding path.
module ws2812_rx #(
  parameter int WS2812_WIDTH  = ws2812_pkg::WS2812_WIDTH,
  parameter int BIT_THRESHOLD = ws2812_pkg::BIT_THRESHOLD,
  parameter int MIN_HIGH      = 4,
  parameter int MAX_HIGH      = 40,
  parameter int RESET_CYCLES  = ws2812_pkg::RESET_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  output logic [WS2812_WIDTH-1:0] data_out,
  output logic                    data_valid,
  output logic                    frame_end,
  output logic                    bit_err,
  output logic [8:0]              word_count
`ifdef WS2812_RX_FORWARD_EN
  ,
  output logic                    dout
`endif
);

  import ws2812_pkg::*;

  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int IW = $clog2(WS2812_WIDTH);

  localparam logic [LW-1:0] LOW_LAST = LW'(RESET_CYCLES - 1);
  localparam logic [LW-1:0] LOW_SAT  = LW'(RESET_CYCLES);
  localparam logic [HW-1:0] HIGH_MAX = HW'(MAX_HIGH);
  localparam logic [HW-1:0] HIGH_MIN = HW'(MIN_HIGH);
  localparam logic [HW-1:0] HIGH_THR = HW'(BIT_THRESHOLD);
  localparam logic [IW-1:0] IDX_LAST = IW'(WS2812_WIDTH - 1);

  logic w_dinS;
  logic w_rise;
  logic w_fall;

  rx_state_t              r_state,      w_stateNext;
  logic [LW-1:0]          r_low,        w_lowNext;
  logic [HW-1:0]          r_high,       w_highNext;
  logic [IW-1:0]          r_bitIdx,     w_bitIdxNext;
  logic [WS2812_WIDTH-1:0] r_shift,     w_shiftNext;
  logic [WS2812_WIDTH-1:0] r_dataOut,   w_dataOutNext;
  logic                   r_dataValid,  w_dataValidNext;
  logic                   r_frameEnd,   w_frameEndNext;
  logic                   r_bitErr,     w_bitErrNext;
  logic [8:0]             r_wordCount,  w_wordCountNext;
  logic                   w_bitVal;

  ws2812_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .din_s (w_dinS),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  // State and datapath registers; everything returns to the SYNC idle
  // condition on reset so a fresh gap is needed before decoding resumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SYNC;
      r_low       <= '0;
      r_high      <= '0;
      r_bitIdx    <= '0;
      r_shift     <= '0;
      r_dataOut   <= '0;
      r_dataValid <= 1'b0;
      r_frameEnd  <= 1'b0;
      r_bitErr    <= 1'b0;
      r_wordCount <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_low       <= w_lowNext;
      r_high      <= w_highNext;
      r_bitIdx    <= w_bitIdxNext;
      r_shift     <= w_shiftNext;
      r_dataOut   <= w_dataOutNext;
      r_dataValid <= w_dataValidNext;
      r_frameEnd  <= w_frameEndNext;
      r_bitErr    <= w_bitErrNext;
      r_wordCount <= w_wordCountNext;
    end
  end

  // Next-state and output decode. The high counter is loaded with 1 on the
  // rising edge because that cycle is already high, so at the falling edge
  // r_high equals the pulse length in cycles. The low counter is likewise
  // loaded with 1 on the falling edge. r_low reaching RESET_CYCLES-1 in a
  // cycle with no rising edge means the line has now been low RESET_CYCLES
  // cycles, which ends the frame.
  always_comb begin
    w_stateNext     = r_state;
    w_lowNext       = r_low;
    w_highNext      = r_high;
    w_bitIdxNext    = r_bitIdx;
    w_shiftNext     = r_shift;
    w_dataOutNext   = r_dataOut;
    w_dataValidNext = 1'b0;
    w_frameEndNext  = 1'b0;
    w_bitErrNext    = 1'b0;
    w_wordCountNext = r_wordCount;
    w_bitVal        = 1'b0;

    case (r_state)
      ST_SYNC: begin
        if (w_dinS) begin
          w_lowNext = '0;
        end else if (r_low == LOW_LAST) begin
          w_lowNext   = LOW_SAT;
          w_stateNext = ST_LOW;
        end else begin
          w_lowNext = r_low + 1'b1;
        end
      end

      ST_LOW: begin
        if (w_rise) begin
          w_stateNext = ST_HIGH;
          w_highNext  = HW'(1);
          w_lowNext   = '0;
        end else if (r_low == LOW_LAST) begin
          w_lowNext       = LOW_SAT;
          w_frameEndNext  = 1'b1;
          w_wordCountNext = '0;
          w_bitIdxNext    = '0;
          if (r_bitIdx != '0) begin
            w_bitErrNext = 1'b1;
          end
        end else if (r_low != LOW_SAT) begin
          w_lowNext = r_low + 1'b1;
        end
      end

      ST_HIGH: begin
        if (w_fall) begin
          if (r_high < HIGH_MIN) begin
            w_bitErrNext = 1'b1;
            w_stateNext  = ST_SYNC;
            w_lowNext    = '0;
            w_bitIdxNext = '0;
          end else begin
            w_bitVal              = (r_high > HIGH_THR);
            w_shiftNext[r_bitIdx] = w_bitVal;
            w_stateNext           = ST_LOW;
            w_lowNext             = LW'(1);
            if (r_bitIdx == IDX_LAST) begin
              w_dataOutNext   = w_shiftNext;
              w_dataValidNext = 1'b1;
              w_bitIdxNext    = '0;
              if (r_wordCount != 9'h1FF) begin
                w_wordCountNext = r_wordCount + 9'd1;
              end
            end else begin
              w_bitIdxNext = r_bitIdx + 1'b1;
            end
          end
        end else if (r_high >= HIGH_MAX) begin
          w_bitErrNext = 1'b1;
          w_stateNext  = ST_SYNC;
          w_lowNext    = '0;
          w_bitIdxNext = '0;
        end else begin
          w_highNext = r_high + 1'b1;
        end
      end

      default: begin
        w_stateNext = ST_SYNC;
        w_lowNext   = '0;
      end
    endcase
  end

  assign data_out   = r_dataOut;
  assign data_valid = r_dataValid;
  assign frame_end  = r_frameEnd;
  assign bit_err    = r_bitErr;
  assign word_count = r_wordCount;

`ifdef WS2812_RX_FORWARD_EN
  logic r_fwdEn;
  logic r_dout;
  logic w_fwdEnNext;

  // Forwarding opens once the first word of a frame has been consumed and
  // closes again on frame end or any error, like a chained LED passing on
  // the remainder of the frame.
  always_comb begin
    w_fwdEnNext = r_fwdEn;
    if (w_frameEndNext || w_bitErrNext) begin
      w_fwdEnNext = 1'b0;
    end else if (w_dataValidNext) begin
      w_fwdEnNext = 1'b1;
    end
  end

  // The forwarded line is the synchronized input retimed by one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwdEn <= 1'b0;
      r_dout  <= 1'b0;
    end else begin
      r_fwdEn <= w_fwdEnNext;
      r_dout  <= w_fwdEnNext & w_dinS;
    end
  end

  assign dout = r_dout;
`endif

endmodule
